// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC transmit path.
//   mac_tx_fcs_state_e : framing state machine encoding for mac_tx_fcs
//   CRC32_POLY         : IEEE 802.3 CRC-32 generator polynomial (normal form)
//   ETH_MIN_FRAME_LEN  : minimum frame length in bytes, excluding the FCS
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_PAD     = 2'd2,
    ST_FCS     = 2'd3
  } mac_tx_fcs_state_e;

  localparam logic [31:0] CRC32_POLY        = 32'h04C11DB7;
  localparam int unsigned ETH_MIN_FRAME_LEN = 60;

endpackage

// File: rtl/mac_lfsr.sv
// mac_lfsr: combinational LFSR / CRC step over one DATA_WIDTH-bit word.
// The caller owns the state register; this block only computes the next
// state, starting from lfsr_init instead of lfsr_state_in when rst is high.
// Ports:
//   rst            in  start from lfsr_init (frame start)
//   lfsr_init      in  LFSR_WIDTH  initial state
//   lfsr_state_in  in  LFSR_WIDTH  current state
//   data_in        in  DATA_WIDTH  word to absorb
//   lfsr_state_out out LFSR_WIDTH  state after absorbing data_in
// LFSR_CONFIG selects "GALOIS" or Fibonacci feedback; REVERSE=1 processes
// data LSB first with a bit-reversed polynomial (reflected CRC).
module mac_lfsr
  import mac_pkg::*;
#(
  parameter int unsigned           LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = CRC32_POLY,
  parameter string                 LFSR_CONFIG = "GALOIS",
  parameter bit                    REVERSE     = 1'b1,
  parameter int unsigned           DATA_WIDTH  = 8
) (
  input  logic                  rst,
  input  logic [LFSR_WIDTH-1:0] lfsr_init,
  input  logic [LFSR_WIDTH-1:0] lfsr_state_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [LFSR_WIDTH-1:0] lfsr_state_out
);

  function automatic logic [LFSR_WIDTH-1:0] bit_rev(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_EFF  = REVERSE ? bit_rev(LFSR_POLY) : LFSR_POLY;
  localparam bit                    IS_GALOIS = (LFSR_CONFIG == "GALOIS");

  always_comb begin
    logic [LFSR_WIDTH-1:0] s;
    logic                  fb;
    logic                  d;
    s  = rst ? lfsr_init : lfsr_state_in;
    fb = 1'b0;
    d  = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      d = REVERSE ? data_in[i] : data_in[DATA_WIDTH-1-i];
      if (IS_GALOIS) begin
        if (REVERSE) begin
          fb = s[0] ^ d;
          s  = s >> 1;
        end else begin
          fb = s[LFSR_WIDTH-1] ^ d;
          s  = s << 1;
        end
        if (fb) s = s ^ POLY_EFF;
      end else begin
        fb = (^(s & POLY_EFF)) ^ d;
        s  = REVERSE ? {fb, s[LFSR_WIDTH-1:1]} : {s[LFSR_WIDTH-2:0], fb};
      end
    end
    lfsr_state_out = s;
  end

endmodule

// File: rtl/mac_tx_fcs.sv
// mac_tx_fcs: Ethernet TX framing stage. Passes payload bytes from a byte
// AXI-Stream, zero-pads short frames to MIN_FRAME_LEN (when MAC_TX_PAD_EN is
// defined) and appends the 4-byte CRC-32 FCS, LSB first. An input frame
// ending with tuser=1 is forwarded as aborted (tlast+tuser, no FCS).
// Ports:
//   clk, rst (async, active low)
//   s_axis_tdata/tvalid/tready/tlast/tuser : payload input, tuser = abort
//   m_axis_tdata/tvalid/tready/tlast/tuser : framed output, one register stage
// Build macro: MAC_TX_PAD_EN enables the PAD state; without it short frames
// are sent unpadded and MIN_FRAME_LEN has no effect.
module mac_tx_fcs
  import mac_pkg::*;
#(
  parameter int unsigned MIN_FRAME_LEN = ETH_MIN_FRAME_LEN,
  parameter logic [31:0] CRC_INIT      = 32'hFFFF_FFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser
);

  mac_tx_fcs_state_e state;
  logic [31:0]       crc_q;
  logic [31:0]       crc_next;
  logic [31:0]       fcs_q;
  logic [1:0]        fcs_idx;
  logic              run;
  logic              load;
  logic              s_fire;
  logic              frame_start;
  logic [7:0]        crc_byte;

`ifdef MAC_TX_PAD_EN
  localparam logic [16:0] MIN_LEN = 17'(MIN_FRAME_LEN);
  logic [15:0] count;
  logic [16:0] count_inc;
  assign count_inc = {1'b0, count} + 17'd1;
  assign crc_byte  = (state == ST_PAD) ? 8'h00 : s_axis_tdata;
`else
  assign crc_byte  = s_axis_tdata;
`endif

  // Output register takes a new beat when empty or draining this cycle.
  assign load        = !m_axis_tvalid || m_axis_tready;
  // run keeps tready low while reset is asserted and for the first edge after.
  assign s_axis_tready = run && load && (state == ST_IDLE || state == ST_PAYLOAD);
  assign s_fire      = s_axis_tready && s_axis_tvalid;
  assign frame_start = (state == ST_IDLE);

  mac_lfsr #(
    .LFSR_WIDTH (32),
    .LFSR_POLY  (CRC32_POLY),
    .LFSR_CONFIG("GALOIS"),
    .REVERSE    (1'b1),
    .DATA_WIDTH (8)
  ) u_crc (
    .rst           (frame_start),
    .lfsr_init     (CRC_INIT),
    .lfsr_state_in (crc_q),
    .data_in       (crc_byte),
    .lfsr_state_out(crc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      crc_q         <= CRC_INIT;
      fcs_q         <= '0;
      fcs_idx       <= '0;
      run           <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
`ifdef MAC_TX_PAD_EN
      count         <= '0;
`endif
    end else begin
      run <= 1'b1;
      if (load) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        m_axis_tuser  <= 1'b0;
        case (state)
          ST_IDLE, ST_PAYLOAD: begin
            if (s_fire) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= s_axis_tdata;
              state         <= ST_PAYLOAD;
`ifdef MAC_TX_PAD_EN
              if (count_inc <= MIN_LEN) count <= count_inc[15:0];
`endif
              if (s_axis_tlast && s_axis_tuser) begin
                m_axis_tlast <= 1'b1;
                m_axis_tuser <= 1'b1;
                state        <= ST_IDLE;
                crc_q        <= CRC_INIT;
`ifdef MAC_TX_PAD_EN
                count        <= '0;
`endif
              end else begin
                crc_q <= crc_next;
                if (s_axis_tlast) begin
                  fcs_idx <= '0;
`ifdef MAC_TX_PAD_EN
                  if (count_inc < MIN_LEN) begin
                    state <= ST_PAD;
                  end else begin
                    state <= ST_FCS;
                    fcs_q <= ~crc_next;
                  end
`else
                  state <= ST_FCS;
                  fcs_q <= ~crc_next;
`endif
                end
              end
            end
          end
`ifdef MAC_TX_PAD_EN
          ST_PAD: begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= 8'h00;
            crc_q         <= crc_next;
            count         <= count_inc[15:0];
            if (count_inc >= MIN_LEN) begin
              state <= ST_FCS;
              fcs_q <= ~crc_next;
            end
          end
`endif
          ST_FCS: begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= fcs_q[7:0];
            fcs_q         <= fcs_q >> 8;
            fcs_idx       <= fcs_idx + 2'd1;
            if (fcs_idx == 2'd3) begin
              m_axis_tlast <= 1'b1;
              state        <= ST_IDLE;
              crc_q        <= CRC_INIT;
`ifdef MAC_TX_PAD_EN
              count        <= '0;
`endif
            end
          end
          default: begin
            state <= ST_IDLE;
            crc_q <= CRC_INIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_tx_fcs.sv
module tb_mac_tx_fcs;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

`ifdef MAC_TX_PAD_EN
  localparam int PAD_ON = 1;
`else
  localparam int PAD_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic       m_axis_tuser;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit cap_en = 0;
  bit stall_mode = 0;
  int tlast_seen = 0;
  int nrdy = 0;
  beat_t got_q[$];
  int    got_cyc[$];
  beat_t exp_q[$];
  logic [7:0] pay[$];

  mac_tx_fcs dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) m_axis_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;

  // Records every beat that will transfer on the following rising edge.
  always @(negedge clk) begin
    #2;
    if (cap_en) begin
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
        got_cyc.push_back(cyc);
        if (m_axis_tlast) tlast_seen++;
      end
      if (!s_axis_tready) nrdy++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] crc32(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Appends the expected output beats for one input frame to exp_q.
  function automatic void build_exp(input logic [7:0] p[$], input bit abort);
    logic [7:0]  f[$];
    logic [31:0] fcs;
    f = p;
    if (abort) begin
      foreach (f[i]) exp_q.push_back({f[i], (i == f.size() - 1), (i == f.size() - 1)});
      return;
    end
    if (PAD_ON != 0) while (f.size() < 60) f.push_back(8'h00);
    fcs = crc32(f);
    foreach (f[i]) exp_q.push_back({f[i], 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) exp_q.push_back({fcs[8*k +: 8], (k == 3), 1'b0});
  endfunction

  task automatic start_capture();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    tlast_seen = 0;
    nrdy = 0;
    cap_en = 1;
  endtask

  task automatic drive_frame(input logic [7:0] b[$], input bit abort);
    for (int i = 0; i < b.size(); i++) begin
      bit acc;
      int guard;
      acc = 0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b[i];
        s_axis_tlast  = (i == b.size() - 1);
        s_axis_tuser  = abort && (i == b.size() - 1);
        #1;
        acc = s_axis_tready;
        @(posedge clk);
        guard++;
        if (!acc && guard > 500) begin
          checks++;
          errors++;
          $display("FAIL input_accept byte %0d: tready stayed 0 for %0d cycles, required 1", i, guard);
          return;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_tlast(input int n, input string name);
    int g;
    g = 0;
    while (tlast_seen < n && g < 3000) begin
      @(negedge clk);
      #3;
      g++;
    end
    checks++;
    if (tlast_seen < n) begin
      errors++;
      $display("FAIL %s_end: saw %0d tlast beats, required %0d", name, tlast_seen, n);
    end
    repeat (2) @(negedge clk);
    cap_en = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h required 00", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b required 0", m_axis_tlast); end
    checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser: got %b required 0", m_axis_tuser); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_sready: got %b required 0", s_axis_tready); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_check_string();
    logic [31:0] fcs_got;
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    start_capture();
    build_exp(pay, 0);
    drive_frame(pay, 0);
    idle_inputs();
    wait_tlast(1, "check_str");
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL check_str_len: got %0d beats required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL check_str beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
`ifndef MAC_TX_PAD_EN
    if (got_q.size() == 13) begin
      fcs_got = {got_q[12].d, got_q[11].d, got_q[10].d, got_q[9].d};
      checks++;
      if (fcs_got !== 32'hCBF43926) begin errors++; $display("FAIL check_str_fcs: got %h required cbf43926", fcs_got); end
    end
`endif
  endtask

  task automatic test_pad();
    int exp_beats;
    int exp_nrdy;
    exp_beats = (PAD_ON != 0) ? 64 : 18;
    exp_nrdy  = (PAD_ON != 0) ? 50 : 4;
    pay.delete();
    for (int i = 0; i < 14; i++) pay.push_back(8'(i * 17 + 3));
    start_capture();
    build_exp(pay, 0);
    drive_frame(pay, 0);
    idle_inputs();
    wait_tlast(1, "pad");
    checks++;
    if (got_q.size() !== exp_beats) begin errors++; $display("FAIL pad_len: got %0d beats required %0d", got_q.size(), exp_beats); end
    checks++;
    if (nrdy !== exp_nrdy) begin errors++; $display("FAIL pad_tready_low: got %0d cycles required %0d", nrdy, exp_nrdy); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL pad beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'($urandom_range(0, 255)));
    start_capture();
    build_exp(pay, 0);
    stall_mode = 1;
    drive_frame(pay, 0);
    idle_inputs();
    wait_tlast(1, "stall");
    stall_mode = 0;
    checks++;
    if (got_q.size() !== 68) begin errors++; $display("FAIL stall_len: got %0d beats required 68", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] nxt[$];
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'(8'hA0 + i));
    nxt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    start_capture();
    build_exp(pay, 1);
    build_exp(nxt, 0);
    drive_frame(pay, 1);
    drive_frame(nxt, 0);
    idle_inputs();
    wait_tlast(2, "abort");
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL abort_len: got %0d beats required %0d", got_q.size(), exp_q.size()); end
    checks++;
    if (got_q.size() > 19 && got_q[19] !== {8'hB3, 1'b1, 1'b1}) begin
      errors++; $display("FAIL abort_last: got %h required %h", got_q[19], {8'hB3, 1'b1, 1'b1});
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f2[$];
    pay.delete();
    for (int i = 0; i < 60; i++) begin
      pay.push_back(8'(i * 7 + 1));
      f2.push_back(8'(8'hFF - i * 3));
    end
    start_capture();
    build_exp(pay, 0);
    build_exp(f2, 0);
    drive_frame(pay, 0);
    drive_frame(f2, 0);
    idle_inputs();
    wait_tlast(2, "b2b");
    checks++;
    if (got_q.size() !== 128) begin errors++; $display("FAIL b2b_len: got %0d beats required 128", got_q.size()); end
    if (got_q.size() == 128) begin
      checks++;
      if (got_cyc[127] - got_cyc[0] !== 127) begin
        errors++; $display("FAIL b2b_span: got %0d cycles required 127", got_cyc[127] - got_cyc[0]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    pay.delete();
    for (int i = 0; i < 14; i++) pay.push_back(8'(8'h55 + i));
    cap_en = 0;
    drive_frame(pay, 0);
    idle_inputs();
    #3;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid %0d: got %b required 0", k, m_axis_tvalid); end
      checks++;
      if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL midrst_sready %0d: got %b required 0", k, s_axis_tready); end
      @(negedge clk);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(i ^ 8'h5A));
    start_capture();
    build_exp(pay, 0);
    drive_frame(pay, 0);
    idle_inputs();
    wait_tlast(1, "midrst");
    checks++;
    if (got_q.size() !== 64) begin errors++; $display("FAIL midrst_len: got %0d beats required 64", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst beat %0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_check_string();
    test_pad();
    test_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
